// File: rtl/ddbb256_cfg_enum.sv
// ddbb256 config-space enumerator: scans device slots, sizes BAR0-2,
// assigns aligned bases from a linear window and enables each device.
module ddbb256_cfg_enum #(
  parameter logic [7:0]  CFG_BUS   = 8'd0,
  parameter logic [4:0]  FIRST_DEV = 5'd0,
  parameter logic [4:0]  LAST_DEV  = 5'd31,
  parameter logic [31:0] MEM_BASE  = 32'h40000000,
  parameter logic [31:0] MEM_LIMIT = 32'h7FFFFFFF,
  parameter logic [7:0]  TIMEOUT   = 8'd63,
  parameter logic [15:0] TID       = 16'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [31:0]  dev_map_o,
  output logic [31:0]  next_adr_o,
  output logic         cs_config_o,
  output logic         cyc_o,
  output logic         we_o,
  output logic [31:0]  sel_o,
  output logic [31:0]  adr_o,
  output logic [255:0] dat_o,
  output logic [15:0]  tid_o,
  input  logic [255:0] dat_i,
  input  logic         ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ID, S_WR_ONES, S_RD_MASK,
    S_ALLOC0, S_ALLOC1, S_ALLOC2,
    S_WR_BAR, S_NEXT, S_FIN
  } state_t;

  state_t         r_state;
  logic [4:0]     r_dev;
  logic           r_cyc;
  logic           r_we;
  logic [31:0]    r_sel;
  logic [31:0]    r_adr;
  logic [255:0]   r_dat;
  logic [7:0]     r_cnt;
  logic [95:0]    r_mask;
  logic [95:0]    r_base;
  logic [2:0]     r_used;
  logic [31:0]    r_ptr;
  logic [31:0]    r_map;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic [1:0]     w_idx;
  state_t         w_alloc_nxt;
  logic [31:0]    w_mask;
  logic [31:0]    w_size;
  logic [32:0]    w_sum;
  logic [31:0]    w_base;
  logic [32:0]    w_end;
  logic [32:0]    w_last;
  logic           w_ovf;
  logic           w_we;
  logic [31:0]    w_sel;
  logic [255:0]   w_dat;
  logic [31:0]    w_adr;
  logic           w_vid_bad;
  logic           w_unused;

  assign w_unused = ^{dat_i[255:224], dat_i[127:16]};

  assign w_adr = {4'h0, CFG_BUS[6:0], r_dev,
                  3'b000, 4'h0, 4'h0, 5'h0};

  assign w_vid_bad = (dat_i[15:0] == 16'h0000) ||
                     (dat_i[15:0] == 16'hFFFF);

  always_comb begin
    w_idx       = 2'd0;
    w_alloc_nxt = S_WR_BAR;
    unique case (r_state)
      S_ALLOC0: begin
        w_idx       = 2'd0;
        w_alloc_nxt = S_ALLOC1;
      end
      S_ALLOC1: begin
        w_idx       = 2'd1;
        w_alloc_nxt = S_ALLOC2;
      end
      S_ALLOC2: begin
        w_idx       = 2'd2;
        w_alloc_nxt = S_WR_BAR;
      end
      default: begin
        w_idx       = 2'd0;
        w_alloc_nxt = S_WR_BAR;
      end
    endcase
  end

  // Natural alignment: round ptr up to the BAR size, all in 33 bits
  assign w_mask = r_mask[{w_idx, 5'd0} +: 32];
  assign w_size = ~w_mask + 32'd1;
  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_size} - 33'd1;
  assign w_base = w_sum[31:0] & w_mask;
  assign w_end  = {1'b0, w_base} + {1'b0, w_size};
  assign w_last = w_end - 33'd1;
  assign w_ovf  = w_sum[32] | w_end[32] |
                  (w_last > {1'b0, MEM_LIMIT});

  always_comb begin
    w_we  = 1'b0;
    w_sel = 32'h0;
    w_dat = '0;
    unique case (r_state)
      S_WR_ONES: begin
        w_we            = 1'b1;
        w_sel[27:16]    = 12'hFFF;
        w_dat[223:128]  = {96{1'b1}};
      end
      S_WR_BAR: begin
        w_we            = 1'b1;
        w_sel[9:8]      = 2'b11;
        w_sel[19:16]    = {4{r_used[0]}};
        w_sel[23:20]    = {4{r_used[1]}};
        w_sel[27:24]    = {4{r_used[2]}};
        w_dat[71:64]    = 8'h06;
        w_dat[223:128]  = r_base;
      end
      default: begin
        w_we  = 1'b0;
        w_sel = 32'hFFFFFFFF;
        w_dat = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_dev   <= FIRST_DEV;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 32'h0;
      r_adr   <= 32'h0;
      r_dat   <= '0;
      r_cnt   <= 8'h0;
      r_mask  <= '0;
      r_base  <= '0;
      r_used  <= 3'b000;
      r_ptr   <= MEM_BASE;
      r_map   <= 32'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RD_ID;
            r_dev   <= FIRST_DEV;
            r_ptr   <= MEM_BASE;
            r_map   <= 32'h0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_RD_ID, S_WR_ONES, S_RD_MASK, S_WR_BAR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_cnt <= 8'h0;
            r_we  <= w_we;
            r_sel <= w_sel;
            r_dat <= w_dat;
            r_adr <= w_adr;
          end else if (ack_i || (r_cnt == TIMEOUT)) begin
            // Dropping cyc here guarantees an idle cycle before the next one
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 32'h0;
            r_dat <= '0;
            r_adr <= 32'h0;
            if (!ack_i) begin
              r_state <= S_NEXT;
            end else if (r_state == S_RD_ID) begin
              r_state <= w_vid_bad ? S_NEXT : S_WR_ONES;
            end else if (r_state == S_WR_ONES) begin
              r_state <= S_RD_MASK;
            end else if (r_state == S_RD_MASK) begin
              r_mask  <= dat_i[223:128] & {3{32'hFFFFFFF0}};
              r_state <= S_ALLOC0;
            end else begin
              r_map[r_dev] <= 1'b1;
              r_state      <= S_NEXT;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ALLOC0, S_ALLOC1, S_ALLOC2: begin
          if ((w_mask != 32'h0) && w_ovf) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_used[w_idx] <= (w_mask != 32'h0);
            r_base[{w_idx, 5'd0} +: 32] <=
              (w_mask != 32'h0) ? w_base : 32'h0;
            if (w_mask != 32'h0) r_ptr <= w_end[31:0];
            r_state <= w_alloc_nxt;
          end
        end
        S_NEXT: begin
          if (r_dev == LAST_DEV) begin
            r_state <= S_FIN;
          end else begin
            r_dev   <= r_dev + 5'd1;
            r_state <= S_RD_ID;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dev_map_o   = r_map;
  assign next_adr_o  = r_ptr;
  assign cs_config_o = r_cyc;
  assign cyc_o       = r_cyc;
  assign we_o        = r_we;
  assign sel_o       = r_sel;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;
  assign tid_o       = TID;

endmodule

// File: tb/tb_ddbb256_cfg_enum.sv
// Bench for ddbb256_cfg_enum: behavioural config slaves, vector table
// of scan scenarios, plus reset/error/start-while-busy sequences.
module tb_ddbb256_cfg_enum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start1;
  logic         start2;
  logic [255:0] dat_i = '0;
  logic         ack_i = 1'b0;

  logic         busy1, done1, err1, cs1, cyc1, we1;
  logic [31:0]  map1, nxt1, sel1, adr1;
  logic [255:0] dato1;
  logic [15:0]  tid1;

  logic         busy2, done2, err2, cs2, cyc2, we2;
  logic [31:0]  map2, nxt2, sel2, adr2;
  logic [255:0] dato2;
  logic [15:0]  tid2;

  ddbb256_cfg_enum u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .err_o(err1),
    .dev_map_o(map1), .next_adr_o(nxt1),
    .cs_config_o(cs1), .cyc_o(cyc1), .we_o(we1),
    .sel_o(sel1), .adr_o(adr1), .dat_o(dato1),
    .tid_o(tid1), .dat_i(dat_i), .ack_i(ack_i)
  );

  ddbb256_cfg_enum #(
    .LAST_DEV(5'd3),
    .MEM_LIMIT(32'h400FFFFF)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2),
    .busy_o(busy2), .done_o(done2), .err_o(err2),
    .dev_map_o(map2), .next_adr_o(nxt2),
    .cs_config_o(cs2), .cyc_o(cyc2), .we_o(we2),
    .sel_o(sel2), .adr_o(adr2), .dat_o(dato2),
    .tid_o(tid2), .dat_i(dat_i), .ack_i(ack_i)
  );

  logic         use2;
  logic         m_busy, m_done, m_err, m_cs, m_cyc, m_we;
  logic [31:0]  m_map, m_nxt, m_sel, m_adr;
  logic [255:0] m_dat;
  logic [15:0]  m_tid;
  logic [4:0]   m_dev;

  assign m_busy = use2 ? busy2 : busy1;
  assign m_done = use2 ? done2 : done1;
  assign m_err  = use2 ? err2  : err1;
  assign m_cs   = use2 ? cs2   : cs1;
  assign m_cyc  = use2 ? cyc2  : cyc1;
  assign m_we   = use2 ? we2   : we1;
  assign m_map  = use2 ? map2  : map1;
  assign m_nxt  = use2 ? nxt2  : nxt1;
  assign m_sel  = use2 ? sel2  : sel1;
  assign m_adr  = use2 ? adr2  : adr1;
  assign m_dat  = use2 ? dato2 : dato1;
  assign m_tid  = use2 ? tid2  : tid1;
  assign m_dev  = m_adr[20:16];

  // Slave model: fixed 3-cycle ack latency, one ack per cyc assertion
  logic [31:0] present;
  logic [15:0] ven [32];
  logic [31:0] msk [32][3];
  logic [31:0] bar [32][3];
  logic [15:0] cmd [32];
  logic [31:0] lsel [32];
  int          wcnt [32];
  logic        s_clr;
  int          s_lat;
  logic        s_done;

  always @(posedge clk) begin
    ack_i <= 1'b0;
    if (s_clr) begin
      for (int d = 0; d < 32; d++) begin
        cmd[d]  <= 16'h0;
        lsel[d] <= 32'h0;
        wcnt[d] <= 0;
        for (int k = 0; k < 3; k++) bar[d][k] <= 32'h0;
      end
      s_lat  <= 0;
      s_done <= 1'b0;
    end else if (!m_cyc) begin
      s_lat  <= 0;
      s_done <= 1'b0;
    end else if (!s_done && present[m_dev]) begin
      if (s_lat < 2) begin
        s_lat <= s_lat + 1;
      end else begin
        ack_i  <= 1'b1;
        s_done <= 1'b1;
        if (m_we) begin
          wcnt[m_dev] <= wcnt[m_dev] + 1;
          lsel[m_dev] <= m_sel;
          if (m_sel[8]) cmd[m_dev] <= m_dat[79:64];
          for (int k = 0; k < 3; k++)
            if (m_sel[16+4*k])
              bar[m_dev][k] <= m_dat[128+32*k +: 32] & msk[m_dev][k];
        end else begin
          dat_i <= {32'h0, bar[m_dev][2], bar[m_dev][1],
                    bar[m_dev][0], 112'h0, ven[m_dev]};
        end
      end
    end
  end

  int n_err;
  int n_chk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slaves();
    present = 32'h0;
    for (int d = 0; d < 32; d++) begin
      ven[d] = 16'h0;
      for (int k = 0; k < 3; k++) msk[d][k] = 32'h0;
    end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!m_done && n < budget) begin
      tick();
      n++;
    end
    chk({nm, " done"}, {31'h0, m_done}, 32'h1);
  endtask

  task automatic scan(input string nm, input bit two);
    if (two) start2 = 1'b1;
    else     start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    chk({nm, " busy"}, {31'h0, m_busy}, 32'h1);
    chk({nm, " done_clr"}, {31'h0, m_done}, 32'h0);
    wait_done(nm, 5000);
  endtask

  typedef struct {
    int          da;
    logic [15:0] va;
    logic [31:0] a0, a1, a2;
    int          db;
    logic [15:0] vb;
    logic [31:0] b0;
    logic [31:0] exp_map;
    logic [31:0] exp_next;
    logic [31:0] exp_abar0;
    logic [31:0] exp_abar1;
    logic [31:0] exp_asel;
    logic [31:0] exp_bbar0;
  } vec_t;

  vec_t vt [6];

  initial begin
    n_err  = 0;
    n_chk  = 0;
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    use2   = 1'b0;
    s_clr  = 1'b0;

    vt[0] = '{-1, 16'h0, 32'h0, 32'h0, 32'h0, -1, 16'h0, 32'h0,
              32'h0, 32'h40000000, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{3, 16'h8086, 32'hFFF00000, 32'hFFFFF000, 32'h0,
              -1, 16'h0, 32'h0,
              32'h8, 32'h40101000, 32'h40000000, 32'h40100000,
              32'h00FF0300, 32'h0};
    vt[2] = '{1, 16'h1234, 32'hFFFFF000, 32'h0, 32'h0,
              2, 16'h5678, 32'hFFF00000,
              32'h6, 32'h40200000, 32'h40000000, 32'h0,
              32'h000F0300, 32'h40100000};
    vt[3] = '{6, 16'h0001, 32'hFFFFFFF0, 32'h0, 32'h0,
              5, 16'hFFFF, 32'hFFF00000,
              32'h40, 32'h40000010, 32'h40000000, 32'h0,
              32'h000F0300, 32'h0};
    vt[4] = '{7, 16'h0A0A, 32'h0, 32'h0, 32'h0,
              -1, 16'h0, 32'h0,
              32'h80, 32'h40000000, 32'h0, 32'h0,
              32'h00000300, 32'h0};
    vt[5] = '{9, 16'h1111, 32'h0, 32'hFFFF0000, 32'h0,
              4, 16'h0000, 32'hFFF00000,
              32'h200, 32'h40010000, 32'h0, 32'h40000000,
              32'h00F00300, 32'h0};

    clear_slaves();
    repeat (3) tick();
    chk("rst busy", {31'h0, m_busy}, 32'h0);
    chk("rst done", {31'h0, m_done}, 32'h0);
    chk("rst err", {31'h0, m_err}, 32'h0);
    chk("rst map", m_map, 32'h0);
    chk("rst next", m_nxt, 32'h40000000);
    chk("rst cyc", {31'h0, m_cyc}, 32'h0);
    chk("rst cs", {31'h0, m_cs}, 32'h0);
    chk("rst adr", m_adr, 32'h0);
    chk("rst tid", {16'h0, m_tid}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      clear_slaves();
      if (vt[i].da >= 0) begin
        present[vt[i].da] = 1'b1;
        ven[vt[i].da]     = vt[i].va;
        msk[vt[i].da][0]  = vt[i].a0;
        msk[vt[i].da][1]  = vt[i].a1;
        msk[vt[i].da][2]  = vt[i].a2;
      end
      if (vt[i].db >= 0) begin
        present[vt[i].db] = 1'b1;
        ven[vt[i].db]     = vt[i].vb;
        msk[vt[i].db][0]  = vt[i].b0;
      end
      scan($sformatf("v%0d", i), 1'b0);
      chk($sformatf("v%0d map", i), m_map, vt[i].exp_map);
      chk($sformatf("v%0d next", i), m_nxt, vt[i].exp_next);
      chk($sformatf("v%0d err", i), {31'h0, m_err}, 32'h0);
      if (vt[i].da >= 0) begin
        chk($sformatf("v%0d a.bar0", i), bar[vt[i].da][0],
            vt[i].exp_abar0);
        chk($sformatf("v%0d a.bar1", i), bar[vt[i].da][1],
            vt[i].exp_abar1);
        chk($sformatf("v%0d a.sel", i), lsel[vt[i].da],
            vt[i].exp_asel);
        chk($sformatf("v%0d a.cmd", i), {16'h0, cmd[vt[i].da]},
            32'h00000006);
        chk($sformatf("v%0d a.writes", i), wcnt[vt[i].da], 32'd2);
      end
      if (vt[i].db >= 0) begin
        if (vt[i].exp_map[vt[i].db])
          chk($sformatf("v%0d b.bar0", i), bar[vt[i].db][0],
              vt[i].exp_bbar0);
        else
          chk($sformatf("v%0d b.writes", i), wcnt[vt[i].db], 32'd0);
      end
    end

    // Window exhausted on the first BAR of dev 0
    use2 = 1'b1;
    clear_slaves();
    present[0] = 1'b1;
    ven[0]     = 16'h10EE;
    msk[0][0]  = 32'hFFE00000;
    scan("ovf", 1'b1);
    chk("ovf err", {31'h0, m_err}, 32'h1);
    chk("ovf map", m_map, 32'h0);
    chk("ovf writes", wcnt[0], 32'd1);
    chk("ovf lastsel", lsel[0], 32'h0FFF0000);
    use2 = 1'b0;

    // Reset while the all-ones write is on the bus
    clear_slaves();
    present[3] = 1'b1;
    ven[3]     = 16'h8086;
    msk[3][0]  = 32'hFFF00000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    begin
      int n;
      n = 0;
      while (!(m_cyc && m_we) && n < 4000) begin
        tick();
        n++;
      end
      chk("wr1 seen", {31'h0, m_cyc & m_we}, 32'h1);
    end
    chk("wr1 adr", m_adr, 32'h00030000);
    rst = 1'b1;
    tick();
    chk("mrst cyc", {31'h0, m_cyc}, 32'h0);
    chk("mrst busy", {31'h0, m_busy}, 32'h0);
    chk("mrst done", {31'h0, m_done}, 32'h0);
    chk("mrst we", {31'h0, m_we}, 32'h0);
    chk("mrst sel", m_sel, 32'h0);
    chk("mrst next", m_nxt, 32'h40000000);
    rst = 1'b0;
    tick();

    // start_i while busy must not restart the scan
    clear_slaves();
    present[3] = 1'b1;
    ven[3]     = 16'h8086;
    msk[3][0]  = 32'hFFF00000;
    msk[3][1]  = 32'hFFFFF000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    begin
      int n;
      n = 0;
      while (!m_map[3] && n < 4000) begin
        tick();
        n++;
      end
      chk("ign map3", m_map, 32'h8);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("ign map kept", m_map, 32'h8);
    chk("ign busy", {31'h0, m_busy}, 32'h1);
    wait_done("ign", 5000);
    chk("ign writes", wcnt[3], 32'd2);
    chk("ign next", m_nxt, 32'h40101000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
